bitbang_transmitter: RTL

Byte-serial bit-bang transmitter. It drives a three-wire data/clock/reset link (TxD, TxC, TxR) into a `bitbang_receiver` on the far side. Each accepted byte is shifted out LSB first, with one TxC rising edge per bit, and TxC is paced from `clk` by a programmable divider. The block sits between the miner's result/response path and the host-facing bit-bang pins, and it also owns the link resynchronisation pulse on TxR.

---
 rtl/bitbang_pkg.sv | 16 +
 rtl/bitbang_transmitter_if.sv | 28 ++
 rtl/bitbang_phase_timer.sv | 29 ++
 rtl/bitbang_transmitter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/bitbang_pkg.sv
// bitbang_pkg: shared types and constants for the bit-bang link.
// Used by both the transmitter and the receiver side.
package bitbang_pkg;

    localparam int BB_BITS     = 8;
    localparam int BB_CNT_W    = 8;
    localparam int BB_MIN_HALF = 4;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        SETUP,
        HIGH
    } bb_state_t;

endpackage

// File: rtl/bitbang_transmitter_if.sv
// bitbang_transmitter_if: host-side byte/resync handshake of the transmitter.
// master = host, slave = transmitter.
interface bitbang_transmitter_if;
    import bitbang_pkg::*;

    logic               TxD_start;
    logic [BB_BITS-1:0] TxD_data;
    logic               TxR_req;
    logic               TxD_busy;
    logic               TxD_done;

    modport master (
        output TxD_start,
        output TxD_data,
        output TxR_req,
        input  TxD_busy,
        input  TxD_done
    );

    modport slave (
        input  TxD_start,
        input  TxD_data,
        input  TxR_req,
        output TxD_busy,
        output TxD_done
    );

endinterface

// File: rtl/bitbang_phase_timer.sv
// bitbang_phase_timer: loadable down-counter, terminal count at zero.
// Shared between the resync pulse and the TxC half-phases.
module bitbang_phase_timer
    import bitbang_pkg::*;
#(
    parameter logic [BB_CNT_W-1:0] RST_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [BB_CNT_W-1:0] i_load_val,
    output logic                o_tc
);

    logic [BB_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/bitbang_transmitter.sv
// bitbang_transmitter: shifts bytes out LSB first on TxD/TxC and owns TxR.
// All link outputs are registered from the next state so they never glitch.
module bitbang_transmitter
    import bitbang_pkg::*;
#(
    parameter int HALF_PERIOD   = 4,
    parameter int RESYNC_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    bitbang_transmitter_if.slave        bus,
    output logic                        TxD,
    output logic                        TxC,
    output logic                        TxR
);

    localparam int HP_EFF = (HALF_PERIOD < BB_MIN_HALF) ? BB_MIN_HALF : HALF_PERIOD;
    localparam logic [BB_CNT_W-1:0] LD_HALF = BB_CNT_W'(HP_EFF - 1);
    localparam logic [BB_CNT_W-1:0] LD_RES  = BB_CNT_W'(RESYNC_CYCLES - 1);
    localparam logic [2:0]          LAST_BIT = 3'(BB_BITS - 1);

    bb_state_t          r_state;
    bb_state_t          w_state_nxt;
    logic [BB_BITS-1:0] r_shift;
    logic [BB_BITS-1:0] w_shift_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic               r_txd;
    logic               r_txc;
    logic               r_txr;
    logic               r_busy;
    logic               r_done;
    logic               w_txd_nxt;
    logic               w_txc_nxt;
    logic               w_txr_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_load;
    logic [BB_CNT_W-1:0] w_load_val;
    logic               w_tc;

    bitbang_phase_timer #(
        .RST_VAL (LD_RES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESYNC;
            r_shift <= '0;
            r_bit   <= '0;
            r_txd   <= 1'b0;
            r_txc   <= 1'b0;
            r_txr   <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_txd   <= w_txd_nxt;
            r_txc   <= w_txc_nxt;
            r_txr   <= w_txr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_load      = 1'b0;
        w_load_val  = LD_HALF;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            RESYNC: begin
                if (w_tc) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                // Resync wins; a start in the same cycle is dropped.
                if (bus.TxR_req) begin
                    w_state_nxt = RESYNC;
                    w_load      = 1'b1;
                    w_load_val  = LD_RES;
                end else if (bus.TxD_start) begin
                    w_shift_nxt = bus.TxD_data;
                    w_bit_nxt   = '0;
                    w_state_nxt = SETUP;
                    w_load      = 1'b1;
                end
            end
            SETUP: begin
                if (w_tc) begin
                    w_state_nxt = HIGH;
                    w_load      = 1'b1;
                end
            end
            HIGH: begin
                if (w_tc) begin
                    w_load = 1'b1;
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_bit_nxt   = r_bit + 3'd1;
                        w_state_nxt = SETUP;
                    end
                end
            end
        endcase

        w_txr_nxt  = (w_state_nxt == RESYNC);
        w_txc_nxt  = (w_state_nxt == HIGH);
        w_busy_nxt = (w_state_nxt != IDLE);
        w_txd_nxt  = (w_state_nxt == SETUP || w_state_nxt == HIGH) ?
                     w_shift_nxt[0] : 1'b0;
    end

    assign TxD          = r_txd;
    assign TxC          = r_txc;
    assign TxR          = r_txr;
    assign bus.TxD_busy = r_busy;
    assign bus.TxD_done = r_done;

endmodule
